alu_jump_unit: RTL and testbench
================================

Name: alu_jump_unit

Overview:
Parametrised successor of the single-cycle JALR executor. It handles both JAL and JALR and computes the target, the link value and the misaligned-target flag. Instructions pass through a registered output stage with a valid/ready handshake, and a flush input kills the in-flight result. The unit sits in the execute stage and drives the fetch redirect and the writeback port. Idle outputs are driven to 0, never high-impedance.

Parameters:
XLEN, 32, datapath width for pc, operands and results
ILEN_BYTES, 4, link increment (pc + ILEN_BYTES); must be 2 or 4
IALIGN_MASK, 3, target bits that must be zero; 3 for 32-bit-only, 1 when compressed is supported
RAS_DEPTH, 4, return-address-stack entries (used only with ALU_JUMP_RAS_EN); power of two, at least 2

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
flush  in  1  kill the held result; takes priority over accept
in_valid  in  1  request valid
in_ready  out  1  unit can accept this cycle
op_jalr  in  1  1 = JALR, 0 = JAL
pc  in  XLEN  pc of the jump instruction
rs1_value  in  XLEN  JALR base
immediate  in  XLEN  sign-extended imm (J-type or I-type)
rs1_index  in  5  JALR source register index
rd_index  in  5  destination register index
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
next_pc  out  XLEN  redirect target
rd_value  out  XLEN  link value
rd_index_out  out  5  registered rd_index
rd_write  out  1  writeback enable
misaligned  out  1  instruction-address-misaligned trap request
ras_hit  out  1  popped prediction equals next_pc (0 when the macro is absent)

Behaviour:
- Reset (synchronous, active-high): out_valid, next_pc, rd_value, rd_index_out, rd_write, misaligned and ras_hit are all 0. The RAS pointer and occupancy count are 0.
- in_ready = !out_valid || out_ready, forced to 0 while flush or reset is high.
- Accept occurs when in_valid && in_ready. The result is registered, so latency is 1 cycle: out_valid rises the cycle after accept.
- Holding state: the output registers hold unchanged while out_valid && !out_ready.
- Throughput: back-to-back accepts are allowed whenever out_ready is 1, giving 1 instruction per cycle.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY to FULL on accept.
  - FULL to FULL on accept while out_ready.
  - FULL to EMPTY on out_ready without accept.
  - Any state to EMPTY on flush; the flushed result is discarded.
- Target computation:
  - JAL: pc + immediate.
  - JALR: (rs1_value + immediate) with bit 0 cleared.
  - All sums are modulo 2^XLEN; overflow wraps silently.
- Link value: rd_value = pc + ILEN_BYTES, modulo 2^XLEN, so pc = all-ones minus 3 wraps to 0 when ILEN_BYTES = 4.
- misaligned = |(target & IALIGN_MASK). On a misaligned target:
  - rd_write = 0;
  - next_pc still carries the faulting target for mtval;
  - the RAS is not updated.
- rd_write = (rd_index != 0) && !misaligned.
- When out_valid = 0, all data outputs read 0.
- When flush and in_valid are high in the same cycle, no accept occurs.
- Reset asserted mid-transfer drops the held result with no handshake completion.

Optional Feature:
Macro: ALU_JUMP_RAS_EN
- With the macro, an alu_jump_ras instance is present. A link register is x1 or x5.
  - Push rd_value when rd is a link register.
  - Pop when the instruction is JALR, rs1 is a link register and rs1 != rd.
  - When both pop and push apply, pop first, then push.
  - Updates happen only on accept and only when the target is not misaligned.
  - Overflow overwrites the oldest entry; the pointer is circular.
  - Underflow (count = 0) pops a prediction of 0, so ras_hit = 0.
  - ras_hit is registered alongside next_pc.
  - flush does not roll back the RAS.
- Without the macro, ras_hit is tied to 0 and no RAS storage is built.

Decomposition:
- Package alu_jump_pkg holds:
  - the XLEN default;
  - the LINK_REG_X1 and LINK_REG_X5 constants;
  - the op encoding constants OP_JAL and OP_JALR;
  - the output-stage state encoding EMPTY/FULL.
- One natural sub-module: alu_jump_ras, containing the stack array, pointer, count and the push/pop logic.

Test Plan:
- JAL, pc=0x100, imm=0x20, rd=1, out_ready=1 -> next cycle: out_valid=1, next_pc=0x120, rd_value=0x104, rd_write=1, misaligned=0.
- JALR, rs1_value=0x2003, imm=0, rd=0 -> next_pc=0x2002, misaligned=1 (IALIGN_MASK=3), rd_write=0.
- Backpressure: accept A, hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable on A; raise out_ready -> B accepted the same cycle, and B appears 1 cycle later.
- Wrap: JAL, pc=0xFFFFFFFC, imm=8 -> next_pc=0x4, rd_value=0x0.
- Flush while FULL and in_valid=1 -> out_valid=0 next cycle, no accept that cycle.
- RAS (macro on): JAL rd=1 at pc=0x40, then JALR rs1=1, rd=0, rs1_value=0x44 -> ras_hit=1; a second return with an empty stack -> ras_hit=0.

Source files
------------

// File: rtl/alu_jump_pkg.sv
// Shared constants and types for the JAL/JALR execute unit.
// The return-address stack is built only when ALU_JUMP_RAS_EN is defined.
package alu_jump_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [4:0] LINK_REG_X1 = 5'd1;
    localparam logic [4:0] LINK_REG_X5 = 5'd5;

    localparam logic OP_JAL  = 1'b0;
    localparam logic OP_JALR = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

    function automatic logic is_link_reg(input logic [4:0] index);
        return (index == LINK_REG_X1) || (index == LINK_REG_X5);
    endfunction

endpackage

// File: rtl/alu_jump_ras.sv
// Circular return-address stack; the oldest entry is overwritten on overflow.
// Instantiated by alu_jump_unit only when ALU_JUMP_RAS_EN is defined.
module alu_jump_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_value,
    output logic [XLEN-1:0] prediction,
    output logic            valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    // ptr names the next free slot, so the top entry sits one below it
    assign top_ptr    = ptr - PTR_W'(1);
    assign valid      = (count != '0);
    assign prediction = valid ? stack[top_ptr] : '0;
    assign do_pop     = pop && valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_pop && push) begin
            ptr   <= ptr;
            count <= count;
        end else if (do_pop) begin
            ptr   <= top_ptr;
            count <= count - CNT_W'(1);
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // A pop followed by a push in the same cycle replaces the top entry
    always_ff @(posedge clock) begin
        if (push) begin
            stack[do_pop ? top_ptr : ptr] <= push_value;
        end
    end

endmodule

// File: rtl/alu_jump_unit.sv
// JAL/JALR executor with a one-entry registered output stage and valid/ready handshake.
// Define ALU_JUMP_RAS_EN to add the return-address stack and drive ras_hit.
module alu_jump_unit
    import alu_jump_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int ILEN_BYTES  = 4,
    parameter int IALIGN_MASK = 3,
    parameter int RAS_DEPTH   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] immediate,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rd_index,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] rd_value,
    output logic [4:0]      rd_index_out,
    output logic            rd_write,
    output logic            misaligned,
    output logic            ras_hit
);

    stage_state_t    state;
    stage_state_t    state_next;
    logic            accept;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_value;
    logic            target_misaligned;
    logic            write_enable;

    assign in_ready = ((state == EMPTY) || out_ready) && !flush && !reset;
    assign accept   = in_valid && in_ready;
    assign out_valid = (state == FULL);

    always_comb begin
        target = '0;
        if (op_jalr == OP_JALR) begin
            target    = rs1_value + immediate;
            target[0] = 1'b0;
        end else begin
            target = pc + immediate;
        end
    end

    assign link_value        = pc + XLEN'(ILEN_BYTES);
    assign target_misaligned = |(target & XLEN'(IALIGN_MASK));
    assign write_enable      = (rd_index != 5'd0) && !target_misaligned;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Registers are cleared whenever the stage goes empty so idle outputs read 0
    always_ff @(posedge clock) begin
        if (reset || (state_next == EMPTY)) begin
            next_pc      <= '0;
            rd_value     <= '0;
            rd_index_out <= '0;
            rd_write     <= 1'b0;
            misaligned   <= 1'b0;
        end else if (accept) begin
            next_pc      <= target;
            rd_value     <= link_value;
            rd_index_out <= rd_index;
            rd_write     <= write_enable;
            misaligned   <= target_misaligned;
        end
    end

`ifdef ALU_JUMP_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_prediction;
    logic            ras_nonempty;
    logic            ras_hit_q;

    assign ras_pop  = accept && (op_jalr == OP_JALR) && is_link_reg(rs1_index)
                      && (rs1_index != rd_index) && !target_misaligned;
    assign ras_push = accept && is_link_reg(rd_index) && !target_misaligned;

    alu_jump_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock      (clock),
        .reset      (reset),
        .push       (ras_push),
        .pop        (ras_pop),
        .push_value (link_value),
        .prediction (ras_prediction),
        .valid      (ras_nonempty)
    );

    always_ff @(posedge clock) begin
        if (reset || (state_next == EMPTY)) begin
            ras_hit_q <= 1'b0;
        end else if (accept) begin
            ras_hit_q <= ras_pop && ras_nonempty && (ras_prediction == target);
        end
    end

    assign ras_hit = ras_hit_q;
`else
    logic unused_rs1_index;
    assign unused_rs1_index = ^rs1_index;
    assign ras_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_jump_unit.sv
// Self-checking bench for alu_jump_unit: directed cases plus randomized traffic against a behavioural model.
// Covers the RAS path as well when ALU_JUMP_RAS_EN is defined.
module tb_alu_jump_unit;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, op_jalr;
    logic [31:0] pc, rs1_value, immediate;
    logic [4:0]  rs1_index, rd_index;
    logic        out_valid, out_ready;
    logic [31:0] next_pc, rd_value;
    logic [4:0]  rd_index_out;
    logic        rd_write, misaligned, ras_hit;

    int checks   = 0;
    int failures = 0;

    bit          exp_full;
    logic [31:0] exp_next_pc, exp_rd_value;
    logic [4:0]  exp_rd_index;
    bit          exp_rd_write, exp_mis, exp_hit;
    logic [31:0] ras_model[$];

    always #5 clock = ~clock;

    alu_jump_unit dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_jalr      (op_jalr),
        .pc           (pc),
        .rs1_value    (rs1_value),
        .immediate    (immediate),
        .rs1_index    (rs1_index),
        .rd_index     (rd_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .next_pc      (next_pc),
        .rd_value     (rd_value),
        .rd_index_out (rd_index_out),
        .rd_write     (rd_write),
        .misaligned   (misaligned),
        .ras_hit      (ras_hit)
    );

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Model of one clock edge, written from the architectural rules
    task automatic stepModel();
        bit          ready_now;
        bit          acc;
        logic [31:0] t;
        ready_now = (!exp_full || out_ready) && !flush && !reset;
        acc       = in_valid && ready_now;
        if (reset) begin
            exp_full = 0;
            ras_model.delete();
        end else if (flush) begin
            exp_full = 0;
        end else if (acc) begin
            t = op_jalr ? ((rs1_value + immediate) & 32'hFFFF_FFFE) : (pc + immediate);
            exp_full     = 1;
            exp_next_pc  = t;
            exp_mis      = (t % 4) != 0;
            exp_rd_value = pc + 32'd4;
            exp_rd_index = rd_index;
            exp_rd_write = (rd_index != 0) && !exp_mis;
            exp_hit      = 0;
`ifdef ALU_JUMP_RAS_EN
            if (!exp_mis) begin
                if (op_jalr && is_link(rs1_index) && rs1_index != rd_index && ras_model.size() > 0) begin
                    exp_hit = (ras_model[$] == t);
                    void'(ras_model.pop_back());
                end
                if (is_link(rd_index)) begin
                    ras_model.push_back(pc + 32'd4);
                    if (ras_model.size() > 4) void'(ras_model.pop_front());
                end
            end
`endif
        end else if (exp_full && out_ready) begin
            exp_full = 0;
        end
    endtask

    task automatic checkOutput();
        compare("out_valid",    {31'd0, out_valid},    {31'd0, exp_full});
        compare("next_pc",      next_pc,               exp_full ? exp_next_pc : 32'd0);
        compare("rd_value",     rd_value,              exp_full ? exp_rd_value : 32'd0);
        compare("rd_index_out", {27'd0, rd_index_out}, exp_full ? {27'd0, exp_rd_index} : 32'd0);
        compare("rd_write",     {31'd0, rd_write},     {31'd0, exp_full && exp_rd_write});
        compare("misaligned",   {31'd0, misaligned},   {31'd0, exp_full && exp_mis});
        compare("ras_hit",      {31'd0, ras_hit},      {31'd0, exp_full && exp_hit});
    endtask

    // One full cycle: drive, check in_ready, clock the model, check registered outputs
    task automatic applyStimulus(input logic v, input logic jalr, input logic [31:0] pcv,
                                 input logic [31:0] rs1v, input logic [31:0] imm,
                                 input logic [4:0] rs1i, input logic [4:0] rdi,
                                 input logic ordy, input logic fl, input logic rst);
        bit exp_ready;
        in_valid  = v;    op_jalr   = jalr; pc       = pcv;
        rs1_value = rs1v; immediate = imm;  rs1_index = rs1i;
        rd_index  = rdi;  out_ready = ordy; flush    = fl;  reset = rst;
        #1;
        exp_ready = (!exp_full || ordy) && !fl && !rst;
        compare("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        @(posedge clock);
        stepModel();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, ordy, 0, 0);
    endtask

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] rpc, rrs1, rimm;
        exp_full = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        compare("reset_out_valid", {31'd0, out_valid}, 32'd0);
        compare("reset_next_pc", next_pc, 32'd0);

        applyStimulus(1, 0, 32'h100, 0, 32'h20, 0, 5'd1, 1, 0, 0);
        compare("jal_out_valid", {31'd0, out_valid}, 32'd1);
        compare("jal_next_pc", next_pc, 32'h120);
        compare("jal_rd_value", rd_value, 32'h104);
        compare("jal_rd_write", {31'd0, rd_write}, 32'd1);
        compare("jal_misaligned", {31'd0, misaligned}, 32'd0);

        applyStimulus(1, 1, 32'h0, 32'h2003, 32'h0, 5'd2, 5'd0, 1, 0, 0);
        compare("jalr_next_pc", next_pc, 32'h2002);
        compare("jalr_misaligned", {31'd0, misaligned}, 32'd1);
        compare("jalr_rd_write", {31'd0, rd_write}, 32'd0);

        applyStimulus(1, 0, 32'hFFFF_FFFC, 0, 32'h8, 0, 5'd3, 1, 0, 0);
        compare("wrap_next_pc", next_pc, 32'h4);
        compare("wrap_rd_value", rd_value, 32'h0);

        applyStimulus(1, 0, 32'h200, 0, 32'h10, 0, 5'd2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h300, 0, 32'h40, 0, 5'd4, 0, 0, 0);
            compare("bp_in_ready", {31'd0, in_ready}, 32'd0);
            compare("bp_hold_next_pc", next_pc, 32'h210);
        end
        applyStimulus(1, 0, 32'h300, 0, 32'h40, 0, 5'd4, 1, 0, 0);
        compare("bp_b_next_pc", next_pc, 32'h340);
        compare("bp_b_rd_value", rd_value, 32'h304);

        applyStimulus(1, 0, 32'h500, 0, 32'h4, 0, 5'd6, 1, 1, 0);
        compare("flush_out_valid", {31'd0, out_valid}, 32'd0);
        idleCycle(1);
        compare("flush_no_accept", {31'd0, out_valid}, 32'd0);

`ifdef ALU_JUMP_RAS_EN
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 0, 32'h40, 0, 32'h100, 0, 5'd1, 1, 0, 0);
        applyStimulus(1, 1, 32'h140, 32'h44, 32'h0, 5'd1, 5'd0, 1, 0, 0);
        compare("ras_return_hit", {31'd0, ras_hit}, 32'd1);
        applyStimulus(1, 1, 32'h148, 32'h44, 32'h0, 5'd1, 5'd0, 1, 0, 0);
        compare("ras_empty_miss", {31'd0, ras_hit}, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            rpc  = $urandom();
            rrs1 = $urandom();
            rimm = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom()))) : $urandom();
            if ($urandom_range(0, 3) != 0) begin
                rpc  = rpc & 32'hFFFF_FFFC;
                rrs1 = rrs1 & 32'hFFFF_FFFC;
                rimm = rimm & 32'hFFFF_FFFC;
            end
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) rrs1 = rpc + 32'd4 - rimm;
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          rpc, rrs1, rimm, pickReg(), pickReg(),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
